// File: rtl/nanorv32_mem_arbiter.sv
// Two-requester arbiter (instruction fetch + load/store) in front of a ROM bank
// and a RAM bank, each a synchronous memory with one cycle of read latency.
module nanorv32_mem_arbiter #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          code_req,
  input  logic [31:0]   code_addr,
  output logic          code_ack,
  output logic [31:0]   code_rdata,
  output logic          code_err,
  input  logic          data_req,
  input  logic [31:0]   data_addr,
  input  logic [3:0]    data_bytesel,
  input  logic [31:0]   data_wdata,
  output logic          data_ack,
  output logic [31:0]   data_rdata,
  output logic          data_err,
  output logic          rom_en,
  output logic [AW-3:0] rom_addr,
  input  logic [31:0]   rom_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t        code_state, data_state;
  logic          code_sel, data_sel;       // bank of the pending read, 1 = RAM
  logic          code_oor_q, data_oor_q;
  logic [1:0]    prio;                     // [0] ROM bank, [1] RAM bank; 1 = code first
  logic [AW-3:0] rom_addr_q, ram_addr_q;
  logic [31:0]   ram_wdata_q;

  logic          code_oor, data_oor, code_bank, data_bank, data_wr;
  logic [AW-3:0] code_word, data_word;
  logic          code_act, data_act, code_need, data_need, conflict, code_wins;
  logic          code_gnt, data_gnt, code_bank_gnt, data_bank_gnt;
  logic          data_ram_wr, data_rom_wr, data_imm;
  logic          unused_bits;

  assign code_oor  = |code_addr[31:AW+1];
  assign data_oor  = |data_addr[31:AW+1];
  assign code_bank = code_addr[AW];
  assign data_bank = data_addr[AW];
  assign code_word = code_addr[AW-1:2];
  assign data_word = data_addr[AW-1:2];
  assign data_wr   = |data_bytesel;
  assign unused_bits = ^{code_addr[1:0], data_addr[1:0]};

  // A requester in its ack cycle (PEND) is ignored; reset blocks all grants.
  assign code_act  = rst_n && code_req && (code_state == IDLE);
  assign data_act  = rst_n && data_req && (data_state == IDLE);
  assign code_need = code_act && !code_oor;
  assign data_need = data_act && !data_oor && !(data_wr && !data_bank);
  assign conflict  = code_need && data_need && (code_bank == data_bank);
  assign code_wins = prio[code_bank];
  assign code_gnt  = code_act && !(conflict && !code_wins);
  assign data_gnt  = data_act && !(conflict && code_wins);

  assign code_bank_gnt = code_gnt && code_need;
  assign data_bank_gnt = data_gnt && data_need;
  assign data_ram_wr   = data_bank_gnt && data_wr;
  assign data_rom_wr   = data_gnt && !data_oor && !data_bank && data_wr;
  assign data_imm      = data_ram_wr || data_rom_wr;

  // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    rom_en    = 1'b0;
    rom_addr  = rom_addr_q;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    if (code_bank_gnt && !code_bank) begin
      rom_en   = 1'b1;
      rom_addr = code_word;
    end else if (data_bank_gnt && !data_bank) begin
      rom_en   = 1'b1;
      rom_addr = data_word;
    end
    if (code_bank_gnt && code_bank) begin
      ram_en   = 1'b1;
      ram_addr = code_word;
    end else if (data_bank_gnt && data_bank) begin
      ram_en   = 1'b1;
      ram_addr = data_word;
      if (data_ram_wr) begin
        ram_we    = data_bytesel;
        ram_wdata = data_wdata;
      end
    end
  end

  assign code_ack   = (code_state == PEND);
  assign code_err   = code_ack && code_oor_q;
  assign code_rdata = (code_ack && !code_oor_q) ? (code_sel ? ram_rdata : rom_rdata) : 32'h0;

  assign data_ack   = (data_state == PEND) || data_imm;
  assign data_err   = ((data_state == PEND) && data_oor_q) || data_rom_wr;
  assign data_rdata = ((data_state == PEND) && !data_oor_q) ?
                      (data_sel ? ram_rdata : rom_rdata) : 32'h0;

  // NOTE: all state here is plain registers on the async active-low reset; the memories live outside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_state   <= IDLE;
      data_state   <= IDLE;
      code_sel     <= 1'b0;
      data_sel     <= 1'b0;
      code_oor_q   <= 1'b0;
      data_oor_q   <= 1'b0;
      prio         <= 2'b00;
      conflict_cnt <= 16'h0;
      rom_addr_q   <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 32'h0;
    end else begin
      code_state <= code_gnt ? PEND : IDLE;
      data_state <= (data_gnt && !data_imm) ? PEND : IDLE;
      if (code_gnt) begin
        code_sel   <= code_bank;
        code_oor_q <= code_oor;
      end
      if (data_gnt) begin
        data_sel   <= data_bank;
        data_oor_q <= data_oor;
      end
      if (conflict) begin
        prio[code_bank] <= ~prio[code_bank];
        if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      end
      rom_addr_q  <= rom_addr;
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// Directed bench for nanorv32_mem_arbiter: behavioural ROM/RAM banks, per-requester
// scoreboard queues for read data/err, and direct checks of bank strobes and timing.
module tb_nanorv32_mem_arbiter;
  localparam int AW    = 15;
  localparam int WORDS = 2 ** (AW - 2);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          code_req = 1'b0, data_req = 1'b0;
  logic [31:0]   code_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]    data_bytesel = '0;
  logic          code_ack, code_err, data_ack, data_err;
  logic [31:0]   code_rdata, data_rdata;
  logic          rom_en, ram_en;
  logic [AW-3:0] rom_addr, ram_addr;
  logic [31:0]   rom_rdata = '0, ram_rdata = '0, ram_wdata;
  logic [3:0]    ram_we;
  logic [15:0]   conflict_cnt;

  logic [31:0] rom_mem [0:WORDS-1];
  logic [31:0] ram_mem [0:WORDS-1];
  logic [31:0] exp_ram [0:WORDS-1];
  exp_t        code_q[$];
  exp_t        data_q[$];

  int compared = 0, mismatched = 0, cyc = 0, g = 0;
  int code_ack_cyc, data_ack_cyc;
  logic mon_en = 1'b1;
  logic s_rom_en, s_ram_en;
  logic [AW-3:0] s_rom_addr, s_ram_addr;
  logic [3:0] s_ram_we;
  logic [31:0] s_ram_wdata;

  nanorv32_mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .code_req(code_req), .code_addr(code_addr), .code_ack(code_ack),
    .code_rdata(code_rdata), .code_err(code_err),
    .data_req(data_req), .data_addr(data_addr), .data_bytesel(data_bytesel),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .data_err(data_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom_mem[rom_addr];
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (code_ack) begin
        if (code_q.size() == 0) check("code_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = code_q.pop_front();
          check("code_rdata", code_rdata, e.rdata);
          check("code_err", {31'd0, code_err}, {31'd0, e.err});
        end
      end else check("code_rdata_idle", code_rdata, 32'h0);
      if (data_ack) begin
        if (data_q.size() == 0) check("data_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = data_q.pop_front();
          check("data_rdata", data_rdata, e.rdata);
          check("data_err", {31'd0, data_err}, {31'd0, e.err});
        end
      end else check("data_rdata_idle", data_rdata, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_code(input logic [31:0] a, input logic [31:0] rd, input logic err);
    exp_t e;
    code_req  = 1'b1;
    code_addr = a;
    e.rdata = rd;
    e.err   = err;
    code_q.push_back(e);
    g = cyc;
  endtask

  task automatic start_data(input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wd,
                            input logic [31:0] rd, input logic err);
    exp_t e;
    data_req     = 1'b1;
    data_addr    = a;
    data_bytesel = bs;
    data_wdata   = wd;
    e.rdata = rd;
    e.err   = err;
    data_q.push_back(e);
    g = cyc;
  endtask

  // Steps cycles until both requesters are acked; snapshots bank strobes in the first cycle.
  task automatic run(input int budget);
    int  n = 0;
    logic ca, da;
    code_ack_cyc = -1;
    data_ack_cyc = -1;
    while ((code_req || data_req) && n < budget) begin
      @(negedge clk);
      if (n == 0) begin
        s_rom_en = rom_en;   s_rom_addr = rom_addr;
        s_ram_en = ram_en;   s_ram_addr = ram_addr;
        s_ram_we = ram_we;   s_ram_wdata = ram_wdata;
      end
      ca = code_ack;
      da = data_ack;
      if (ca) code_ack_cyc = cyc;
      if (da) data_ack_cyc = cyc;
      tick();
      if (ca) code_req = 1'b0;
      if (da) data_req = 1'b0;
      n++;
    end
    check("run_timeout", {31'd0, code_req | data_req}, 32'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < WORDS; i++) begin
      rom_mem[i] = 32'hA000_0000 | i;
      ram_mem[i] = 32'hB000_0000 ^ i;
      exp_ram[i] = 32'hB000_0000 ^ i;
    end

    // Reset with both requesters asserting
    code_req = 1'b1; code_addr = 32'h10;
    data_req = 1'b1; data_addr = 32'h8000; data_bytesel = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_code_ack", {31'd0, code_ack}, 32'd0);
    check("rst_data_ack", {31'd0, data_ack}, 32'd0);
    check("rst_code_err", {31'd0, code_err}, 32'd0);
    check("rst_data_err", {31'd0, data_err}, 32'd0);
    check("rst_rom_en", {31'd0, rom_en}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {28'd0, ram_we}, 32'd0);
    check("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    code_req = 1'b0; data_req = 1'b0; data_bytesel = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();

    // Lone code read of ROM word 4
    start_code(32'h10, 32'hA000_0004, 1'b0);
    run(10);
    check("rd_rom_en", {31'd0, s_rom_en}, 32'd1);
    check("rd_rom_addr", {19'd0, s_rom_addr}, 32'd4);
    check("rd_code_lat", code_ack_cyc, g + 1);

    // ROM conflict: data wins first, code wins the next one
    start_code(32'h0, 32'hA000_0000, 1'b0);
    start_data(32'h4, 4'h0, 32'h0, 32'hA000_0001, 1'b0);
    run(10);
    check("cf1_rom_addr", {19'd0, s_rom_addr}, 32'd1);
    check("cf1_data_lat", data_ack_cyc, g + 1);
    check("cf1_code_lat", code_ack_cyc, g + 2);
    check("cf1_cnt", {16'd0, conflict_cnt}, 32'd1);
    start_code(32'h8, 32'hA000_0002, 1'b0);
    start_data(32'hC, 4'h0, 32'h0, 32'hA000_0003, 1'b0);
    run(10);
    check("cf2_rom_addr", {19'd0, s_rom_addr}, 32'd2);
    check("cf2_code_lat", code_ack_cyc, g + 1);
    check("cf2_data_lat", data_ack_cyc, g + 2);
    check("cf2_cnt", {16'd0, conflict_cnt}, 32'd2);

    // RAM partial write, then read back
    exp_ram[2][15:0] = 16'h5678;
    start_data(32'h8008, 4'b0011, 32'h1234_5678, 32'h0, 1'b0);
    run(10);
    check("wr_ram_en", {31'd0, s_ram_en}, 32'd1);
    check("wr_ram_we", {28'd0, s_ram_we}, 32'b0011);
    check("wr_ram_addr", {19'd0, s_ram_addr}, 32'd2);
    check("wr_ram_wdata", s_ram_wdata, 32'h1234_5678);
    check("wr_ack_lat", data_ack_cyc, g);
    start_data(32'h8008, 4'h0, 32'h0, exp_ram[2], 1'b0);
    run(10);
    check("rdback_lat", data_ack_cyc, g + 1);

    // Write to ROM is refused with an error and leaves ROM intact
    start_data(32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1);
    run(10);
    check("romwr_rom_en", {31'd0, s_rom_en}, 32'd0);
    check("romwr_ram_en", {31'd0, s_ram_en}, 32'd0);
    check("romwr_ack_lat", data_ack_cyc, g);
    start_code(32'h100, 32'hA000_0040, 1'b0);
    run(10);

    // Out-of-range code read alongside a RAM data read
    start_code(32'h0001_0000, 32'h0, 1'b1);
    start_data(32'h8010, 4'h0, 32'h0, exp_ram[4], 1'b0);
    run(10);
    check("oor_rom_en", {31'd0, s_rom_en}, 32'd0);
    check("oor_ram_addr", {19'd0, s_ram_addr}, 32'd4);
    check("oor_code_lat", code_ack_cyc, g + 1);
    check("oor_data_lat", data_ack_cyc, g + 1);

    // Different banks in parallel, then idle bank outputs hold their last values
    start_code(32'h20, 32'hA000_0008, 1'b0);
    start_data(32'h8020, 4'h0, 32'h0, exp_ram[8], 1'b0);
    run(10);
    check("par_code_lat", code_ack_cyc, g + 1);
    check("par_data_lat", data_ack_cyc, g + 1);
    check("par_cnt", {16'd0, conflict_cnt}, 32'd2);
    @(negedge clk);
    check("idle_rom_en", {31'd0, rom_en}, 32'd0);
    check("idle_rom_addr", {19'd0, rom_addr}, 32'd8);
    check("idle_ram_addr", {19'd0, ram_addr}, 32'd8);
    check("idle_ram_wdata", ram_wdata, 32'h1234_5678);
    tick();

    // RAM conflict: RAM priority bit still 0, so the data write wins
    exp_ram[1][31:24] = 8'hAA;
    start_code(32'h8000, exp_ram[0], 1'b0);
    start_data(32'h8004, 4'b1000, 32'hAABB_CCDD, 32'h0, 1'b0);
    run(10);
    check("ramcf_we", {28'd0, s_ram_we}, 32'b1000);
    check("ramcf_addr", {19'd0, s_ram_addr}, 32'd1);
    check("ramcf_data_lat", data_ack_cyc, g);
    check("ramcf_code_lat", code_ack_cyc, g + 2);
    check("ramcf_cnt", {16'd0, conflict_cnt}, 32'd3);
    start_data(32'h8004, 4'h0, 32'h0, exp_ram[1], 1'b0);
    run(10);

    // Reset pulse in the cycle after a read grant drops the read
    code_req = 1'b1; code_addr = 32'h14;
    tick();
    rst_n = 1'b0;
    code_req = 1'b0;
    @(negedge clk);
    check("rstmid_code_ack", {31'd0, code_ack}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | code_ack | data_ack;
    end
    check("rstmid_no_ack", {31'd0, seen}, 32'd0);
    check("rstmid_cnt", {16'd0, conflict_cnt}, 32'd0);
    tick();

    // Sustained conflicts: per 3 cycles, data write wins, code read wins, code in ack cycle
    mon_en = 1'b0;
    code_req = 1'b1; code_addr = 32'h8000;
    data_req = 1'b1; data_addr = 32'h8004; data_bytesel = 4'h1; data_wdata = 32'h0;
    repeat (300) @(posedge clk);
    #1;
    check("stress_cnt_200", {16'd0, conflict_cnt}, 32'd200);
    repeat (3 * 32700) @(posedge clk);
    #1;
    check("stress_cnt_sat", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    code_req = 1'b0; data_req = 1'b0;
    tick();
    check("sb_code_empty", code_q.size(), 32'd0);
    check("sb_data_empty", data_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/nanorv32_mem_arbiter.md
NANORV32_MEM_ARBITER -- requirements
Module: nanorv32_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, meaning byte-address width of each bank (32 KB per bank).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: rst_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have ports code_req in 1, code_addr in 32, code_ack out 1, code_rdata out 32, code_err out 1  for the instruction-fetch requester (read-only).
REQ-005 SHALL have ports data_req in 1, data_addr in 32, data_bytesel in 4 (0 = read, nonzero = write byte lanes), data_wdata in 32, data_ack out 1, data_rdata out 32, data_err out 1  for the load/store requester.
REQ-006 SHALL have ports rom_en out 1, rom_addr out AW-2, rom_rdata in 32  for the ROM bank, a synchronous RAM with 1-cycle read latency.
REQ-007 SHALL have ports ram_en out 1, ram_we out 4, ram_addr out AW-2, ram_wdata out 32, ram_rdata in 32  for the RAM bank, same timing.
REQ-008 SHALL have port conflict_cnt  output  16  saturating count of same-bank conflicts.

Function
REQ-009 Decode: addr[31:AW+1] nonzero -> out-of-range; else addr[AW]=0 -> ROM, 1 -> RAM; word index = addr[AW-1:2].
REQ-010 Requesters hold req, addr, bytesel, wdata stable until ack; req seen in a requester's own ack cycle SHALL be ignored (one idle cycle between transactions).
REQ-011 Per requester, state IDLE/PEND: IDLE + grant of a read or out-of-range access -> PEND; PEND -> IDLE unconditionally next cycle with ack=1.
REQ-012 Read: bank en=1 and addr driven in grant cycle N; ack=1 in N+1 with rdata = that bank's rdata, routed by a bank select registered at N.
REQ-013 RAM write: ram_en=1, ram_we=data_bytesel, ram_wdata=data_wdata in grant cycle; data_ack=1 combinationally in the same cycle; no PEND.
REQ-014 ROM write (data port, ROM bank, bytesel nonzero): no bank access; data_ack=1 and data_err=1 in the same cycle.
REQ-015 Out-of-range: no bank access; ack=1, err=1, rdata=0 in the cycle after grant; always granted (no bank contention).
REQ-016 Different banks in the same cycle: both granted, no stall.
REQ-017 Same bank in the same cycle: one winner chosen by that bank's priority bit (0 = data first, 1 = code first); the bit toggles only on a conflict, so the loser wins the next conflict; the loser stays IDLE and retries.
REQ-018 Each conflict cycle increments conflict_cnt by 1, saturating at 16'hFFFF.
REQ-019 err is only valid while ack=1; rdata is 0 whenever ack=0.
REQ-020 Bank outputs when idle: en=0, we=0; addr and wdata hold their last value.

Reset
REQ-021 During rst_n=0: all acks=0, errs=0, rdata=0, rom_en=ram_en=0, ram_we=0, both states IDLE, both priority bits 0, conflict_cnt=0.
REQ-022 Reset asserted mid-transaction SHALL drop the pending read; no ack after release until a new req is granted.
REQ-023 First grant possible in the first rising edge with rst_n=1.

Verification
REQ-024 Code read 0x0000_0010 alone -> rom_en=1, rom_addr=4 in cycle N; code_ack=1, code_rdata=ROM[4] in N+1; code_err=0.
REQ-025 Code reads 0x0000_0000 and data reads 0x0000_0004 in the same cycle -> data granted first (priority 0), code acked 2 cycles later, conflict_cnt=1; next conflict code wins.
REQ-026 Data write 0x0000_8008, bytesel=4'b0011, wdata=0x1234_5678 -> ram_we=0011, ram_addr=2, data_ack=1 in the same cycle; a read of 0x8008 returns 0x????_5678 with the low 16 bits updated.
REQ-027 Data write 0x0000_0100 (ROM) -> rom_en=0, data_ack=1 and data_err=1 same cycle; ROM contents unchanged.
REQ-028 Code read 0x0001_0000 -> no en, code_ack=1, code_err=1, code_rdata=0 next cycle; parallel data read to RAM completes unaffected.
REQ-029 rst_n pulsed low in the cycle after a read grant -> no ack after release; 70000 forced conflicts -> conflict_cnt=16'hFFFF.
